// File: rtl/vec_pkg.sv
// Shared types and entry-layout helpers for the vector checker.
// A vector entry is packed as {tag, stim, exp, mask}, mask in the LSBs.
package vec_pkg;

  localparam int DEF_IN_W  = 65;
  localparam int DEF_OUT_W = 100;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_SETTLE = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Entry field offsets, derived from the stimulus and output widths.
  function automatic int mask_lsb(input int in_w, input int out_w);
    return 0 * (in_w + out_w);
  endfunction

  function automatic int exp_lsb(input int in_w, input int out_w);
    return mask_lsb(in_w, out_w) + out_w;
  endfunction

  function automatic int stim_lsb(input int in_w, input int out_w);
    return exp_lsb(in_w, out_w) + out_w;
  endfunction

  function automatic int tag_bit(input int in_w, input int out_w);
    return stim_lsb(in_w, out_w) + in_w;
  endfunction

endpackage

// File: rtl/vec_cmp.sv
// Masked compare of DUT outputs against expected values.
// A mask bit of 0 marks the corresponding output bit as don't-care.
module vec_cmp
  import vec_pkg::*;
#(
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic [OUT_W-1:0] i_act,
  input  logic [OUT_W-1:0] i_exp,
  input  logic [OUT_W-1:0] i_mask,
  output logic             o_mismatch
);

  assign o_mismatch = |((i_act ^ i_exp) & i_mask);

endmodule

// File: rtl/vec_checker.sv
// Vector-driven checker: walks a synchronous vector memory, drives each
// stimulus, waits a settle period, then compares masked DUT outputs.
// Stops at the first entry with tag=0 or after the last entry.
module vec_checker
  import vec_pkg::*;
#(
  parameter int  IN_W   = DEF_IN_W,
  parameter int  OUT_W  = DEF_OUT_W,
  parameter int  DEPTH  = 1024,
  parameter int  SETTLE = 2,
  parameter int  CNT_W  = 16,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int ENT_W  = 1 + IN_W + 2 * OUT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_vec_addr,
  input  logic [ENT_W-1:0]  i_vec_data,
  output logic [IN_W-1:0]   o_stim,
  input  logic [OUT_W-1:0]  i_dut_out,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_err_valid,
  output logic [ADDR_W-1:0] o_err_index,
  output logic [CNT_W-1:0]  o_err_cnt,
  output logic [CNT_W-1:0]  o_vec_cnt
);

  localparam int TAG_BIT  = tag_bit(IN_W, OUT_W);
  localparam int STIM_LSB = stim_lsb(IN_W, OUT_W);
  localparam int EXP_LSB  = exp_lsb(IN_W, OUT_W);
  localparam int MASK_LSB = mask_lsb(IN_W, OUT_W);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]        SETTLE_INIT = 4'(SETTLE);

  state_t             r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [IN_W-1:0]    r_stim;
  logic [OUT_W-1:0]   r_exp;
  logic [OUT_W-1:0]   r_mask;
  logic [3:0]         r_settle;
  logic [CNT_W-1:0]   r_err_cnt;
  logic [CNT_W-1:0]   r_vec_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  logic               r_err_valid;
  logic [ADDR_W-1:0]  r_err_index;

  logic               w_tag;
  logic [IN_W-1:0]    w_stim_in;
  logic [OUT_W-1:0]   w_exp_in;
  logic [OUT_W-1:0]   w_mask_in;
  logic               w_mismatch;
  logic [CNT_W-1:0]   w_err_cnt_chk;

  assign w_tag     = i_vec_data[TAG_BIT];
  assign w_stim_in = i_vec_data[STIM_LSB +: IN_W];
  assign w_exp_in  = i_vec_data[EXP_LSB +: OUT_W];
  assign w_mask_in = i_vec_data[MASK_LSB +: OUT_W];

  vec_cmp #(
    .OUT_W (OUT_W)
  ) u_cmp (
    .i_act      (i_dut_out),
    .i_exp      (r_exp),
    .i_mask     (r_mask),
    .o_mismatch (w_mismatch)
  );

  // Error count as it stands after the current CHECK, saturating at all-ones;
  // pass on the final vector must see this value, not the stale register.
  assign w_err_cnt_chk = (w_mismatch && !(&r_err_cnt)) ? r_err_cnt + CNT_W'(1)
                                                        : r_err_cnt;

  // Sequencer: fetch, load, settle and check one entry at a time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_stim      <= '0;
      r_exp       <= '0;
      r_mask      <= '0;
      r_settle    <= '0;
      r_err_cnt   <= '0;
      r_vec_cnt   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_index <= '0;
    end else begin
      // NOTE: err_valid defaults low every cycle, so it can only be a one-cycle pulse.
      r_err_valid <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_err_cnt <= '0;
            r_vec_cnt <= '0;
            r_addr    <= '0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          if (!w_tag) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_err_cnt == '0);
          end else begin
            r_stim   <= w_stim_in;
            r_exp    <= w_exp_in;
            r_mask   <= w_mask_in;
            r_settle <= SETTLE_INIT;
            r_state  <= (SETTLE == 0) ? S_CHECK : S_SETTLE;
          end
        end
        S_SETTLE: begin
          r_settle <= r_settle - 4'd1;
          if (r_settle <= 4'd1) begin
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!(&r_vec_cnt)) begin
            r_vec_cnt <= r_vec_cnt + CNT_W'(1);
          end
          r_err_cnt <= w_err_cnt_chk;
          if (w_mismatch) begin
            r_err_valid <= 1'b1;
            r_err_index <= r_addr;
          end
          if (r_addr == LAST_ADDR) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_cnt_chk == '0);
          end else begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_vec_addr  = r_addr;
  assign o_stim      = r_stim;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_err_valid = r_err_valid;
  assign o_err_index = r_err_index;
  assign o_err_cnt   = r_err_cnt;
  assign o_vec_cnt   = r_vec_cnt;

endmodule

// File: tb/tb_vec_checker.sv
// Bench for vec_checker: three instances (default widths, DEPTH=4, CNT_W=2),
// each with a synchronous vector memory and a pass-through "DUT" whose output
// is the zero-extended stimulus. Expected err/done events go into queues and a
// monitor pops and compares them when the checkers raise err_valid or done.
module tb_vec_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] r_start;

  int checks   = 0;
  int failures = 0;

  // ---------------- instance 0: defaults (IN_W=65, OUT_W=100, SETTLE=2)
  logic [9:0]   addr0;
  logic [265:0] rd0;
  logic [64:0]  stim0;
  logic [99:0]  dut0;
  logic         busy0, done0, pass0, ev0;
  logic [9:0]   eidx0;
  logic [15:0]  ecnt0, vcnt0;
  logic [265:0] mem0 [1024];

  assign dut0 = {35'd0, stim0};
  always @(posedge clk) rd0 <= mem0[addr0];

  vec_checker u_main (
    .clk (clk), .rst_n (rst_n), .i_start (r_start[0]),
    .o_vec_addr (addr0), .i_vec_data (rd0), .o_stim (stim0), .i_dut_out (dut0),
    .o_busy (busy0), .o_done (done0), .o_pass (pass0), .o_err_valid (ev0),
    .o_err_index (eidx0), .o_err_cnt (ecnt0), .o_vec_cnt (vcnt0)
  );

  // ---------------- instance 1: DEPTH=4, SETTLE=1
  logic [1:0]  addr1;
  logic [24:0] rd1;
  logic [7:0]  stim1, dut1;
  logic        busy1, done1, pass1, ev1;
  logic [1:0]  eidx1;
  logic [15:0] ecnt1, vcnt1;
  logic [24:0] mem1 [4];

  assign dut1 = stim1;
  always @(posedge clk) rd1 <= mem1[addr1];

  vec_checker #(.IN_W(8), .OUT_W(8), .DEPTH(4), .SETTLE(1), .CNT_W(16)) u_d4 (
    .clk (clk), .rst_n (rst_n), .i_start (r_start[1]),
    .o_vec_addr (addr1), .i_vec_data (rd1), .o_stim (stim1), .i_dut_out (dut1),
    .o_busy (busy1), .o_done (done1), .o_pass (pass1), .o_err_valid (ev1),
    .o_err_index (eidx1), .o_err_cnt (ecnt1), .o_vec_cnt (vcnt1)
  );

  // ---------------- instance 2: DEPTH=8, SETTLE=0, CNT_W=2
  logic [2:0]  addr2;
  logic [24:0] rd2;
  logic [7:0]  stim2, dut2;
  logic        busy2, done2, pass2, ev2;
  logic [2:0]  eidx2;
  logic [1:0]  ecnt2, vcnt2;
  logic [24:0] mem2 [8];

  assign dut2 = stim2;
  always @(posedge clk) rd2 <= mem2[addr2];

  vec_checker #(.IN_W(8), .OUT_W(8), .DEPTH(8), .SETTLE(0), .CNT_W(2)) u_c2 (
    .clk (clk), .rst_n (rst_n), .i_start (r_start[2]),
    .o_vec_addr (addr2), .i_vec_data (rd2), .o_stim (stim2), .i_dut_out (dut2),
    .o_busy (busy2), .o_done (done2), .o_pass (pass2), .o_err_valid (ev2),
    .o_err_index (eidx2), .o_err_cnt (ecnt2), .o_vec_cnt (vcnt2)
  );

  // ---------------- common per-instance views
  logic [2:0]  w_busy, w_done, w_pass, w_ev;
  logic [31:0] w_addr [3];
  logic [31:0] w_eidx [3];
  logic [31:0] w_ecnt [3];
  logic [31:0] w_vcnt [3];

  assign w_busy = {busy2, busy1, busy0};
  assign w_done = {done2, done1, done0};
  assign w_pass = {pass2, pass1, pass0};
  assign w_ev   = {ev2, ev1, ev0};
  assign w_addr[0] = 32'(addr0);
  assign w_addr[1] = 32'(addr1);
  assign w_addr[2] = 32'(addr2);
  assign w_eidx[0] = 32'(eidx0);
  assign w_eidx[1] = 32'(eidx1);
  assign w_eidx[2] = 32'(eidx2);
  assign w_ecnt[0] = 32'(ecnt0);
  assign w_ecnt[1] = 32'(ecnt1);
  assign w_ecnt[2] = 32'(ecnt2);
  assign w_vcnt[0] = 32'(vcnt0);
  assign w_vcnt[1] = 32'(vcnt1);
  assign w_vcnt[2] = 32'(vcnt2);

  // ---------------- scoreboard
  typedef struct {
    int inst;
    int idx;
  } err_exp_t;

  typedef struct {
    int inst;
    int vec;
    int err;
    int pass;
  } done_exp_t;

  err_exp_t  err_q  [$];
  done_exp_t done_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [127:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  // Entry builders: {tag, stim, exp, mask}.
  function automatic logic [265:0] ent0(input logic tag, input logic [64:0] s,
                                        input logic [99:0] e, input logic [99:0] m);
    return {tag, s, e, m};
  endfunction

  function automatic logic [24:0] ents(input logic tag, input logic [7:0] s,
                                       input logic [7:0] e, input logic [7:0] m);
    return {tag, s, e, m};
  endfunction

  // Monitor: compare every err_valid pulse and every rising done.
  logic [2:0] m_done_prev = 3'b000;
  err_exp_t   m_e;
  done_exp_t  m_d;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (w_ev[i]) begin
        if (err_q.size() == 0) begin
          fail($sformatf("err_unexpected_inst%0d", i), w_eidx[i]);
        end else begin
          m_e = err_q.pop_front();
          check($sformatf("err_inst%0d", i), i, m_e.inst);
          check($sformatf("err_index_inst%0d", i), w_eidx[i], m_e.idx);
        end
      end
      if (w_done[i] && !m_done_prev[i]) begin
        if (done_q.size() == 0) begin
          fail($sformatf("done_unexpected_inst%0d", i), w_vcnt[i]);
        end else begin
          m_d = done_q.pop_front();
          check($sformatf("done_inst%0d", i), i, m_d.inst);
          check($sformatf("vec_cnt_inst%0d", i), w_vcnt[i], m_d.vec);
          check($sformatf("err_cnt_inst%0d", i), w_ecnt[i], m_d.err);
          check($sformatf("pass_inst%0d", i), w_pass[i], m_d.pass);
          check($sformatf("busy_at_done_inst%0d", i), w_busy[i], 0);
        end
      end
    end
    m_done_prev = w_done;
  end

  // Pulse start on instance i and wait for done. n counts clock edges after
  // the edge that sampled start. A start pulse is re-issued when n == poke
  // (the checker is busy then and must ignore it).
  task automatic run_inst(input int i, input int poke, input int bound, output int n);
    @(negedge clk);
    r_start[i] = 1'b1;
    @(negedge clk);
    r_start[i] = 1'b0;
    check($sformatf("busy_after_start_inst%0d", i), w_busy[i], 1);
    n = 0;
    while (!w_done[i] && n < bound) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      r_start[i] = (n == poke);
    end
    r_start[i] = 1'b0;
    if (n >= bound) fail($sformatf("run_timeout_inst%0d", i), n);
  endtask

  localparam logic [99:0] ONES100 = '1;
  localparam logic [64:0] S0 = 65'h1_0123_4567_89AB_CDEF;
  localparam logic [64:0] S1 = 65'h0_FFFF_0000_1234_5678;
  localparam logic [64:0] S2 = 65'h1_DEAD_BEEF_0000_0001;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n   = 1'b0;
    r_start = 3'b000;
    for (int k = 0; k < 1024; k++) mem0[k] = '0;
    for (int k = 0; k < 4; k++) mem1[k] = '0;
    for (int k = 0; k < 8; k++) mem2[k] = '0;

    // Reset values on every instance.
    #3;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_flags_inst%0d", i), {w_busy[i], w_done[i], w_pass[i], w_ev[i]}, 0);
      check($sformatf("rst_addr_inst%0d", i), w_addr[i], 0);
      check($sformatf("rst_err_index_inst%0d", i), w_eidx[i], 0);
      check($sformatf("rst_cnts_inst%0d", i), {w_ecnt[i], w_vcnt[i]}, 0);
    end
    check("rst_stim", stim0, 0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_without_start", w_busy, 0);

    // Three matching vectors, tag=0 at entry 3. Each vector takes
    // FETCH+LOAD+2 SETTLE+CHECK = 5 edges, then FETCH+LOAD of entry 3 -> 17.
    mem0[0] = ent0(1'b1, S0, {35'd0, S0}, ONES100);
    mem0[1] = ent0(1'b1, S1, {35'd0, S1}, ONES100);
    mem0[2] = ent0(1'b1, S2, {35'd0, S2}, ONES100);
    mem0[3] = ent0(1'b0, '0, '0, '0);
    done_q.push_back('{0, 3, 0, 1});
    run_inst(0, -1, 200, n);
    check("t1_cycles", n, 17);
    check("t1_stim_last", stim0, S2);

    // Entry 1: exp=5 vs dut_out=4, full mask; start poked mid-run.
    mem0[1] = ent0(1'b1, 65'h4, 100'h5, ONES100);
    err_q.push_back('{0, 1});
    done_q.push_back('{0, 3, 1, 0});
    run_inst(0, 12, 200, n);
    check("t2_cycles", n, 17);

    // Same mismatch, but bit 0 masked off.
    mem0[1] = ent0(1'b1, 65'h4, 100'h5, ~100'h1);
    done_q.push_back('{0, 3, 0, 1});
    run_inst(0, -1, 200, n);

    // Empty run: entry 0 tag=0, stim keeps its previous value.
    mem0[0] = ent0(1'b0, 65'h1F, 100'h1F, ONES100);
    done_q.push_back('{0, 0, 0, 1});
    run_inst(0, -1, 200, n);
    check("t4_cycles", n, 2);
    check("t4_stim_held", stim0, S2);

    // Reset during SETTLE of entry 2, then a clean re-run.
    mem0[0] = ent0(1'b1, S0, {35'd0, S0}, ONES100);
    mem0[1] = ent0(1'b1, S1, {35'd0, S1}, ONES100);
    @(negedge clk);
    r_start[0] = 1'b1;
    @(negedge clk);
    r_start[0] = 1'b0;
    n = 0;
    while (stim0 !== S2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_reached_entry2", stim0, S2);
    check("t5_busy_before_reset", busy0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_flags", {busy0, done0, pass0, ev0}, 0);
    check("t5_rst_stim", stim0, 0);
    check("t5_rst_addr", addr0, 0);
    check("t5_rst_err_index", eidx0, 0);
    check("t5_rst_cnts", {ecnt0, vcnt0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_idle_after_release", {busy0, addr0}, 0);
    done_q.push_back('{0, 3, 0, 1});
    run_inst(0, -1, 200, n);
    check("t5_rerun_cycles", n, 17);

    // DEPTH=4, all tags set: stops after entry 3 without wrapping.
    // 4 vectors x (FETCH+LOAD+1 SETTLE+CHECK) = 16 edges.
    for (int k = 0; k < 4; k++) begin
      mem1[k] = ents(1'b1, 8'hA0 + 8'(k), 8'hA0 + 8'(k), 8'hFF);
    end
    mem1[3] = ents(1'b1, 8'hA3, 8'h23, 8'hFF);
    err_q.push_back('{1, 3});
    done_q.push_back('{1, 4, 1, 0});
    run_inst(1, -1, 200, n);
    check("d4_cycles", n, 16);
    check("d4_addr_no_wrap", addr1, 3);
    check("d4_stim_last", stim1, 8'hA3);

    // CNT_W=2, five failing vectors: both counters saturate at 3.
    // 5 vectors x 3 edges + FETCH+LOAD of entry 5 = 17; start poked mid-run.
    for (int k = 0; k < 5; k++) begin
      mem2[k] = ents(1'b1, 8'h10 + 8'(k), (8'h10 + 8'(k)) ^ 8'h01, 8'hFF);
      err_q.push_back('{2, k});
    end
    mem2[5] = ents(1'b0, 8'h00, 8'h00, 8'h00);
    done_q.push_back('{2, 3, 3, 0});
    run_inst(2, 4, 200, n);
    check("c2_cycles", n, 17);

    repeat (3) @(negedge clk);
    check("err_q_drained", err_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
